// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/add/shift ops plus multi-cycle shift-add multiply
// and restoring divide sharing one operand/accumulator datapath.
module alu_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic             i_flags_we,
  input  logic [2:0]       i_flags,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [2:0]       o_flags
);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpNot = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpMul = 4'h8;
  localparam logic [3:0] OpDiv = 4'h9;
  localparam logic [3:0] OpMod = 4'hA;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;      // multiplier (MUL) / dividend-then-quotient (DIV)
  logic [WIDTH-1:0] b_q, b_d;      // multiplicand / divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // product high half / partial remainder
  logic             rem_sel_q, rem_sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;

  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
  logic             shift_big, shift_zero;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem;
  logic             last_iter;
  logic             res_we;
  logic [WIDTH-1:0] res_new;
  logic             carry_new;

  // Single-cycle datapath; the extra bit of each vector carries out/in the shifted-out bit
  always_comb begin
    add_full   = {1'b0, i_data_1} + {1'b0, i_data_2};
    sub_full   = {1'b0, i_data_1} - {1'b0, i_data_2};
    shl_full   = {1'b0, i_data_1} << i_data_2;
    shr_full   = {i_data_1, 1'b0} >> i_data_2;
    shift_big  = i_data_2 > WIDTH'(WIDTH);
    shift_zero = i_data_2 == '0;
  end

  // Iteration datapath
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
    div_trial = {1'b0, acc_q, a_q[WIDTH-1]} - {2'b00, b_q};
    div_qbit  = ~div_trial[WIDTH+1];
    div_rem   = div_qbit ? div_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
    last_iter = cnt_q == CNT_W'(WIDTH - 1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_sel_d = rem_sel_q;
    valid_d   = 1'b0;
    res_we    = 1'b0;
    res_new   = result_q;
    carry_new = flags_q[2];

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          valid_d = 1'b1;
          case (i_op)
            OpNot: begin
              res_we  = 1'b1;
              res_new = ~i_data_1;
            end
            OpAdd: begin
              res_we    = 1'b1;
              res_new   = add_full[WIDTH-1:0];
              carry_new = add_full[WIDTH];
            end
            OpSub: begin
              res_we    = 1'b1;
              res_new   = sub_full[WIDTH-1:0];
              carry_new = sub_full[WIDTH];
            end
            OpAnd: begin
              res_we  = 1'b1;
              res_new = i_data_1 & i_data_2;
            end
            OpOr: begin
              res_we  = 1'b1;
              res_new = i_data_1 | i_data_2;
            end
            OpShl: begin
              res_we = 1'b1;
              if (shift_big) begin
                res_new   = '0;
                carry_new = 1'b0;
              end else if (shift_zero) begin
                res_new = i_data_1;
              end else begin
                res_new   = shl_full[WIDTH-1:0];
                carry_new = shl_full[WIDTH];
              end
            end
            OpShr: begin
              res_we = 1'b1;
              if (shift_big) begin
                res_new   = '0;
                carry_new = 1'b0;
              end else if (shift_zero) begin
                res_new = i_data_1;
              end else begin
                res_new   = shr_full[WIDTH:1];
                carry_new = shr_full[0];
              end
            end
            OpMul: begin
              valid_d = 1'b0;
              state_d = StMul;
              cnt_d   = '0;
              a_d     = i_data_2;
              b_d     = i_data_1;
              acc_d   = '0;
            end
            OpDiv, OpMod: begin
              if (i_data_2 == '0) begin
                res_we    = 1'b1;
                res_new   = '1;
                carry_new = 1'b1;
              end else begin
                valid_d   = 1'b0;
                state_d   = StDiv;
                cnt_d     = '0;
                a_d       = i_data_1;
                b_d       = i_data_2;
                acc_d     = '0;
                rem_sel_d = (i_op == OpMod);
              end
            end
            default: ;  // NOP and illegal opcodes only pulse o_valid
          endcase
        end
      end
      StMul: begin
        acc_d = mul_sum[WIDTH:1];
        a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d   = StIdle;
          valid_d   = 1'b1;
          res_we    = 1'b1;
          res_new   = {mul_sum[0], a_q[WIDTH-1:1]};
          carry_new = |mul_sum[WIDTH:1];
        end
      end
      StDiv: begin
        acc_d = div_rem;
        a_d   = {a_q[WIDTH-2:0], div_qbit};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d   = StIdle;
          valid_d   = 1'b1;
          res_we    = 1'b1;
          res_new   = rem_sel_q ? div_rem : {a_q[WIDTH-2:0], div_qbit};
          carry_new = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // External flag load overrides the op's flag update but not its result
  always_comb begin
    result_d = res_we ? res_new : result_q;
    flags_d  = flags_q;
    if (res_we) begin
      flags_d = {carry_new, res_new[WIDTH-1], res_new == '0};
    end
    if (i_flags_we) begin
      flags_d = i_flags;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_sel_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_sel_q <= rem_sel_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign o_ready  = (state_q == StIdle);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=16.
module tb_alu_iter;

  localparam int unsigned WIDTH = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_data_1;
  logic [WIDTH-1:0] i_data_2;
  logic             i_flags_we;
  logic [2:0]       i_flags;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic [2:0]       o_flags;

  int total = 0;
  int bad   = 0;

  alu_iter #(.WIDTH(WIDTH)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_op      (i_op),
    .i_data_1  (i_data_1),
    .i_data_2  (i_data_2),
    .i_flags_we(i_flags_we),
    .i_flags   (i_flags),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_flags   (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] d1, input logic [15:0] d2);
    i_valid  = 1'b1;
    i_op     = op;
    i_data_1 = d1;
    i_data_2 = d2;
    tick();
    i_valid  = 1'b0;
  endtask

  // Single-cycle op: o_valid, result and flags must be visible right after the accept edge
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] er, input logic [2:0] ef);
    issue(op, d1, d2);
    chk({tag, ".valid"}, o_valid, 1'b1);
    chk({tag, ".res"}, o_result, er);
    chk({tag, ".flags"}, o_flags, ef);
  endtask

  // Multi-cycle op: count edges after accept until o_valid, bounded
  task automatic do_multi(input string tag, input logic [3:0] op, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] er, input logic [2:0] ef,
                          input int elat);
    int n;
    issue(op, d1, d2);
    n = 0;
    while (o_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".res"}, o_result, er);
    chk({tag, ".flags"}, o_flags, ef);
    chk({tag, ".ready"}, o_ready, 1'b1);
  endtask

  initial begin
    int seen;
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_op       = 4'h0;
    i_data_1   = '0;
    i_data_2   = '0;
    i_flags_we = 1'b0;
    i_flags    = 3'b000;
    tick();
    tick();
    chk("rst.valid", o_valid, 1'b0);
    chk("rst.res", o_result, 16'h0000);
    chk("rst.flags", o_flags, 3'b000);
    #3 i_rst = 1'b0;
    tick();
    chk("rst.ready", o_ready, 1'b1);

    do_op("add_wrap", 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 3'b101);
    chk("add_wrap.ready", o_ready, 1'b1);
    tick();
    chk("add_wrap.pulse", o_valid, 1'b0);
    do_op("sub_borrow", 4'h3, 16'h0003, 16'h0005, 16'hFFFE, 3'b110);
    do_op("shl_k0", 4'h6, 16'h8001, 16'h0000, 16'h8001, 3'b110);
    do_op("shl_5", 4'h6, 16'h8888, 16'h0005, 16'h1100, 3'b100);
    do_op("nop", 4'h0, 16'h1234, 16'h5678, 16'h1100, 3'b100);
    do_op("illegal", 4'hB, 16'h0005, 16'h0005, 16'h1100, 3'b100);
    do_op("shr_17", 4'h7, 16'h0001, 16'd17, 16'h0000, 3'b001);
    do_op("shr_1", 4'h7, 16'h0003, 16'h0001, 16'h0001, 3'b100);
    do_op("not", 4'h1, 16'h00FF, 16'h0000, 16'hFF00, 3'b110);
    do_op("and", 4'h4, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b100);
    do_op("or", 4'h5, 16'h0F00, 16'h00F0, 16'h0FF0, 3'b100);
    do_op("shl_16", 4'h6, 16'h0001, 16'd16, 16'h0000, 3'b101);

    // MUL with i_valid held high and a different op waiting behind it
    issue(4'h8, 16'h0100, 16'h0100);
    i_valid  = 1'b1;
    i_op     = 4'h2;
    i_data_1 = 16'h0001;
    i_data_2 = 16'h0002;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      if (o_ready !== 1'b0 || o_valid !== 1'b0) seen++;
    end
    chk("mul_hold.busy", seen, 0);
    tick();
    chk("mul_hold.valid", o_valid, 1'b1);
    chk("mul_hold.ready", o_ready, 1'b1);
    chk("mul_hold.res", o_result, 16'h0000);
    chk("mul_hold.flags", o_flags, 3'b101);
    tick();
    i_valid = 1'b0;
    chk("b2b_add.valid", o_valid, 1'b1);
    chk("b2b_add.res", o_result, 16'h0003);
    chk("b2b_add.flags", o_flags, 3'b000);

    do_multi("mul_300_200", 4'h8, 16'd300, 16'd200, 16'hEA60, 3'b010, 16);
    do_multi("div_1000_7", 4'h9, 16'd1000, 16'd7, 16'h008E, 3'b000, 16);
    do_multi("mod_1000_7", 4'hA, 16'd1000, 16'd7, 16'h0006, 3'b000, 16);
    do_multi("div_by0", 4'h9, 16'd5, 16'd0, 16'hFFFF, 3'b110, 0);

    // Reset during iteration 8 of a DIV
    issue(4'h9, 16'd1000, 16'd7);
    for (int i = 0; i < 7; i++) tick();
    i_rst = 1'b1;
    #1;
    chk("rst_mid.valid", o_valid, 1'b0);
    chk("rst_mid.res", o_result, 16'h0000);
    chk("rst_mid.flags", o_flags, 3'b000);
    #3 i_rst = 1'b0;
    tick();
    chk("rst_mid.ready", o_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid !== 1'b0) seen++;
    end
    chk("rst_mid.no_pulse", seen, 0);

    i_flags_we = 1'b1;
    i_flags    = 3'b101;
    do_op("add_fwe", 4'h2, 16'd2, 16'd3, 16'h0005, 3'b101);
    i_flags    = 3'b010;
    tick();
    i_flags_we = 1'b0;
    chk("fwe_only.flags", o_flags, 3'b010);
    chk("fwe_only.res", o_result, 16'h0005);
    chk("fwe_only.valid", o_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
